// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary to 4-digit BCD converter with start/busy/done handshake.
// Optional macro BCD_CLAMP_EN: saturate to 9999 and raise ovf when the value exceeds 9999.
module bin_to_bcd_seq #(
   parameter int WIDTH = 14
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] bin,
   output logic [3:0]       ones,
   output logic [3:0]       tens,
   output logic [3:0]       hundreds,
   output logic [3:0]       thousands,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [19:0]      scratch_q, scratch_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [15:0]      digits_q, digits_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic [19:0]      adj;
   logic             unused_adj_msb;

   // Add-3 correction applied to every nibble before this cycle's shift.
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < 5; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
   end

   // The top bit can never be set for WIDTH <= 14, so it falls off the shift.
   assign unused_adj_msb = adj[19];

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      digits_d  = digits_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d   = bin;
               scratch_d = '0;
               cnt_d     = '0;
               busy_d    = 1'b1;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            scratch_d = {adj[18:0], shift_q[WIDTH-1]};
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST)
               state_d = S_DONE;
         end
         S_DONE: begin
`ifdef BCD_CLAMP_EN
            if (scratch_q[19:16] != 4'd0) begin
               digits_d = 16'h9999;
               ovf_d    = 1'b1;
            end else begin
               digits_d = scratch_q[15:0];
               ovf_d    = 1'b0;
            end
`else
            digits_d = scratch_q[15:0];
            ovf_d    = 1'b0;
`endif
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         digits_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         digits_q  <= digits_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign thousands = digits_q[15:12];
   assign hundreds  = digits_q[11:8];
   assign tens      = digits_q[7:4];
   assign ones      = digits_q[3:0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected digits/ovf/done-cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

   logic        clk_100MHz = 1'b0;
   logic        reset      = 1'b1;
   logic        start      = 1'b0;
   logic [13:0] bin        = '0;
   logic [3:0]  ones, tens, hundreds, thousands;
   logic        busy, done, ovf;

   bin_to_bcd_seq #(.WIDTH(14)) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .start      (start),
      .bin        (bin),
      .ones       (ones),
      .tens       (tens),
      .hundreds   (hundreds),
      .thousands  (thousands),
      .busy       (busy),
      .done       (done),
      .ovf        (ovf)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   int cyc = 0;
   always @(posedge clk_100MHz) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] dig;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk_100MHz) begin
      exp_t e;
      if (!reset && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got digits %h with no request pending (cycle %0d)",
                     {thousands, hundreds, tens, ones}, cyc);
         end else begin
            e = sb.pop_front();
            chk("digits", {16'h0, thousands, hundreds, tens, ones}, {16'h0, e.dig});
            chk("ovf", {31'h0, ovf}, {31'h0, e.ovf});
            chk("done_cycle", cyc, e.cyc);
            chk("busy_at_done", {31'h0, busy}, 32'h0);
            chk("done_single_cycle", {31'h0, prev_done}, 32'h0);
         end
      end
      prev_done = done;
   end

   task automatic issue(input logic [13:0] v, input logic [15:0] d, input logic o);
      @(negedge clk_100MHz);
      start = 1'b1;
      bin   = v;
      sb.push_back('{d, o, cyc + 1 + 15});
      @(negedge clk_100MHz);
      start = 1'b0;
      chk("busy_after_accept", {31'h0, busy}, 32'h1);
   endtask

   task automatic wait_drained();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk_100MHz);
         n++;
      end
      @(negedge clk_100MHz);
      chk("scoreboard_drained", sb.size(), 32'h0);
   endtask

   initial begin
      int a;
      int d1;
      logic gap;

      repeat (3) @(negedge clk_100MHz);
      reset = 1'b0;
      @(negedge clk_100MHz);
      chk("reset_digits", {16'h0, thousands, hundreds, tens, ones}, 32'h0);
      chk("reset_busy", {31'h0, busy}, 32'h0);
      chk("reset_done", {31'h0, done}, 32'h0);
      chk("reset_ovf", {31'h0, ovf}, 32'h0);

      issue(14'd0, 16'h0000, 1'b0);
      wait_drained();
      issue(14'd1234, 16'h1234, 1'b0);
      wait_drained();

      // start held high: 9999 then 5, second done 16 cycles after the first
      @(negedge clk_100MHz);
      start = 1'b1;
      bin   = 14'd9999;
      d1    = cyc + 1 + 15;
      sb.push_back('{16'h9999, 1'b0, d1});
      sb.push_back('{16'h0005, 1'b0, d1 + 16});
      @(negedge clk_100MHz);
      bin = 14'd5;
      while (cyc < d1 + 16) @(negedge clk_100MHz);
      start = 1'b0;
      wait_drained();

`ifdef BCD_CLAMP_EN
      issue(14'd16383, 16'h9999, 1'b1);
`else
      issue(14'd16383, 16'h6383, 1'b0);
`endif
      wait_drained();

      // Requests while busy (including the SHIFT->DONE edge) are dropped
      @(negedge clk_100MHz);
      start = 1'b1;
      bin   = 14'd42;
      a     = cyc + 1;
      sb.push_back('{16'h0042, 1'b0, a + 15});
      gap = 1'b0;
      @(negedge clk_100MHz);
      start = 1'b0;
      bin   = 14'd777;
      if (busy !== 1'b1) gap = 1'b1;
      while (cyc < a + 15) begin
         @(negedge clk_100MHz);
         start = (cyc == a + 2) || (cyc == a + 13);
         if (cyc <= a + 14 && busy !== 1'b1) gap = 1'b1;
      end
      start = 1'b0;
      chk("busy_continuous", {31'h0, gap}, 32'h0);
      repeat (20) @(negedge clk_100MHz);
      chk("ignored_start_idle", {31'h0, busy}, 32'h0);
      wait_drained();

      // Reset in the middle of converting 500: everything clears, no done
      @(negedge clk_100MHz);
      start = 1'b1;
      bin   = 14'd500;
      a     = cyc + 1;
      @(negedge clk_100MHz);
      start = 1'b0;
      while (cyc < a + 7) @(negedge clk_100MHz);
      reset = 1'b1;
      @(negedge clk_100MHz);
      chk("midreset_digits", {16'h0, thousands, hundreds, tens, ones}, 32'h0);
      chk("midreset_busy", {31'h0, busy}, 32'h0);
      chk("midreset_done", {31'h0, done}, 32'h0);
      chk("midreset_ovf", {31'h0, ovf}, 32'h0);
      reset = 1'b0;
      repeat (25) @(negedge clk_100MHz);
      chk("post_reset_busy", {31'h0, busy}, 32'h0);
      chk("post_reset_digits", {16'h0, thousands, hundreds, tens, ones}, 32'h0);
      wait_drained();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
